// File: rtl/slow_access_timer.sv
// slow_access_timer: requests stock CPU speed during enabled slow-device accesses plus a programmable hold window
module slow_access_timer #(
    parameter int PRESCALE = 16,
    parameter int PSW      = 8
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       ClkGateReq,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       Slow,
    output logic       SlowStart,
    output logic [3:0] SlowCount
);
    typedef enum logic [1:0] {IDLE, ACTIVE, COUNT} stateType;

    localparam logic [PSW-1:0] PRELOAD = PSW'(PRESCALE - 1);

    stateType       state, nextState;
    logic           hit, hitR, trig, startNext;
    logic [PSW-1:0] preCnt, preNext;
    logic [3:0]     cntNext;

    assign hit  = (BACT & ((IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                           (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd))) |
                  (ClkGateReq & SlowClockGate);
    assign trig = hit & ~hitR;

    // Next-state logic: a new hit always wins over window expiry, so Slow never glitches low
    always_comb begin
        nextState = state;
        preNext   = preCnt;
        cntNext   = SlowCount;
        startNext = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    nextState = ACTIVE;
                    startNext = trig;
                end
            end
            ACTIVE: begin
                if (!hit) begin
                    nextState = COUNT;
                    cntNext   = SlowTimeout;
                    preNext   = PRELOAD;
                end
            end
            COUNT: begin
                if (hit) begin
                    nextState = ACTIVE;
                    startNext = trig;
                end else if (preCnt != '0) begin
                    preNext = preCnt - 1'b1;
                end else if (SlowCount != 4'd0) begin
                    cntNext = SlowCount - 4'd1;
                    preNext = PRELOAD;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State and registered outputs; Slow mirrors the state being entered so it has no extra latency
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state     <= IDLE;
            hitR      <= 1'b0;
            preCnt    <= '0;
            SlowCount <= 4'd0;
            Slow      <= 1'b0;
            SlowStart <= 1'b0;
        end else begin
            state     <= nextState;
            hitR      <= hit;
            preCnt    <= preNext;
            SlowCount <= cntNext;
            Slow      <= (nextState != IDLE);
            SlowStart <= startNext;
        end
    end
endmodule

// File: tb/tb_slow_access_timer.sv
// tb_slow_access_timer: directed self-checking bench for slow_access_timer with PRESCALE=4
module tb_slow_access_timer;
    logic       CLK = 1'b0, nPOR = 1'b1;
    logic       BACT = 0, IACKCS = 0, VIACS = 0, IWMCS = 0, SCCCS = 0, SCSICS = 0, SndCS = 0, ClkGateReq = 0;
    logic       SlowIACK = 0, SlowVIA = 0, SlowIWM = 0, SlowSCC = 0, SlowSCSI = 0, SlowSnd = 0, SlowClockGate = 0;
    logic [3:0] SlowTimeout = 4'd0;
    logic       Slow, SlowStart;
    logic [3:0] SlowCount;
    int         passCnt = 0, checkCnt = 0;

    slow_access_timer #(.PRESCALE(4), .PSW(8)) dut (
        .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS),
        .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS), .ClkGateReq(ClkGateReq),
        .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
        .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd), .SlowClockGate(SlowClockGate),
        .SlowTimeout(SlowTimeout), .Slow(Slow), .SlowStart(SlowStart), .SlowCount(SlowCount)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input int obs, input int want);
        checkCnt++;
        if (obs == want) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Hit has just been removed: the next edge loads the window, Slow must stay high for span edges then drop
    task automatic holdWindow(input string tag, input int span);
        for (int k = 0; k < span; k++) begin
            step;
            checkVal({tag, "_hold"}, int'(Slow), 1);
        end
        step;
        checkVal({tag, "_end"}, int'(Slow), 0);
    endtask

    initial begin
        // 1: reset with a qualified access pending
        #2 nPOR = 1'b0;
        BACT = 1; VIACS = 1; SlowVIA = 1; SlowTimeout = 4'd0;
        repeat (3) step;
        checkVal("rst_slow", int'(Slow), 0);
        checkVal("rst_start", int'(SlowStart), 0);
        checkVal("rst_count", int'(SlowCount), 0);
        nPOR = 1'b1;
        step;
        checkVal("rel_slow", int'(Slow), 1);
        checkVal("rel_start", int'(SlowStart), 1);
        step;
        checkVal("rel_start2", int'(SlowStart), 0);
        checkVal("rel_slow2", int'(Slow), 1);
        BACT = 0; VIACS = 0;
        holdWindow("t0win", 4);

        // 2: VIA access 5 cycles, timeout 2 -> 12-cycle hold, count 2,1,0
        SlowTimeout = 4'd2;
        BACT = 1; VIACS = 1;
        step;
        checkVal("t2_slow", int'(Slow), 1);
        checkVal("t2_start", int'(SlowStart), 1);
        repeat (4) begin
            step;
            checkVal("t2_act", int'(Slow), 1);
            checkVal("t2_nostart", int'(SlowStart), 0);
        end
        BACT = 0; VIACS = 0;
        for (int k = 0; k < 12; k++) begin
            step;
            checkVal("t2_hold", int'(Slow), 1);
            checkVal("t2_count", int'(SlowCount), 2 - k / 4);
        end
        step;
        checkVal("t2_end", int'(Slow), 0);

        // 3: unqualified SCSI access
        SlowSCSI = 0; SCSICS = 1; BACT = 1;
        repeat (10) begin
            step;
            checkVal("t3_slow", int'(Slow), 0);
            checkVal("t3_start", int'(SlowStart), 0);
        end
        SCSICS = 0; BACT = 0;
        step;

        // 4: retrigger by IWM mid-COUNT, then retrigger on the expiry edge
        SlowIWM = 1;
        BACT = 1; VIACS = 1;
        repeat (5) step;
        BACT = 0; VIACS = 0;
        for (int k = 0; k < 7; k++) begin
            step;
            checkVal("t4_hold1", int'(Slow), 1);
        end
        BACT = 1; IWMCS = 1;
        step;
        checkVal("t4_reslow", int'(Slow), 1);
        checkVal("t4_restart", int'(SlowStart), 1);
        checkVal("t4_frozen", int'(SlowCount), 1);
        repeat (3) begin
            step;
            checkVal("t4_act", int'(Slow), 1);
            checkVal("t4_nostart", int'(SlowStart), 0);
        end
        BACT = 0; IWMCS = 0;
        for (int k = 0; k < 11; k++) begin
            step;
            checkVal("t4_hold2", int'(Slow), 1);
        end
        step;
        checkVal("t4_last", int'(Slow), 1);
        checkVal("t4_lastcnt", int'(SlowCount), 0);
        BACT = 1; IWMCS = 1;
        step;
        checkVal("t4_expslow", int'(Slow), 1);
        checkVal("t4_expstart", int'(SlowStart), 1);
        BACT = 0; IWMCS = 0;
        holdWindow("t4win", 12);

        // 5: timeout change mid-COUNT is ignored until the next access
        SlowTimeout = 4'd2;
        BACT = 1; VIACS = 1;
        step;
        BACT = 0; VIACS = 0;
        step;
        checkVal("t5_load", int'(SlowCount), 2);
        repeat (2) step;
        SlowTimeout = 4'd9;
        for (int k = 3; k < 12; k++) begin
            step;
            checkVal("t5_hold", int'(Slow), 1);
        end
        step;
        checkVal("t5_end", int'(Slow), 0);
        BACT = 1; VIACS = 1;
        step;
        BACT = 0; VIACS = 0;
        step;
        checkVal("t5_load9", int'(SlowCount), 9);
        for (int k = 1; k < 40; k++) begin
            step;
            checkVal("t5_hold40", int'(Slow), 1);
        end
        step;
        checkVal("t5_end40", int'(Slow), 0);

        // 6: asynchronous reset mid-COUNT
        SlowTimeout = 4'd2;
        BACT = 1; VIACS = 1;
        step;
        BACT = 0; VIACS = 0;
        repeat (3) step;
        checkVal("t6_pre", int'(Slow), 1);
        #3 nPOR = 1'b0;
        #1;
        checkVal("t6_slow", int'(Slow), 0);
        checkVal("t6_count", int'(SlowCount), 0);
        checkVal("t6_start", int'(SlowStart), 0);
        #2 nPOR = 1'b1;
        repeat (3) begin
            step;
            checkVal("t6_idle", int'(Slow), 0);
            checkVal("t6_nostart", int'(SlowStart), 0);
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
